// File: rtl/srff_pulse_arbiter.sv
// Round-robin arbiter that serialises set/clear requests into S/R pulses for one shared S-R latch.
// Optional build macro SRFF_SKIP_REDUNDANT_EN: grants whose result already matches q skip the pulse.
//
// state   | meaning
// S_IDLE  | waiting for a pending requester, round-robin from ptr
// S_PULSE | S or R held high for PULSE_W cycles
// S_GAP   | S=R=0 settle time for GAP cycles before q is checked
// S_DONE  | one-cycle ack to the granted requester
module srff_pulse_arbiter #(
  parameter int N       = 2,
  parameter int PULSE_W = 2,
  parameter int GAP     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] set_req,
  input  logic [N-1:0] clr_req,
  input  logic         q,
  output logic         s_out,
  output logic         r_out,
  output logic [N-1:0] ack,
  output logic         busy,
  output logic         err
);
  localparam int MAXC = (PULSE_W > GAP) ? PULSE_W : GAP;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int PW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic          op_set_q, op_set_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [N-1:0]  ack_q, ack_d;

  logic [N-1:0]  pend;
  logic          found;
  logic [PW-1:0] sel;
  logic [PW-1:0] sel_nxt;
  logic [PW:0]   idx;
  logic [PW:0]   nxt;
  logic          ack_en;
  logic [PW-1:0] ack_idx;

  assign pend = set_req | clr_req;

  // First pending requester at or after ptr, wrapping at N.
  always_comb begin : arb
    found   = 1'b0;
    sel     = '0;
    idx     = '0;
    nxt     = '0;
    sel_nxt = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && pend[idx[PW-1:0]]) begin
        found = 1'b1;
        sel   = idx[PW-1:0];
      end
    end
    nxt     = {1'b0, sel} + (PW+1)'(1);
    sel_nxt = (nxt >= (PW+1)'(N)) ? '0 : nxt[PW-1:0];
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    op_set_d = op_set_q;
    s_d      = s_q;
    r_d      = r_q;
    busy_d   = busy_q;
    err_d    = err_q;
    ack_en   = 1'b0;
    ack_idx  = gnt_q;
    ack_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d    = sel;
          ptr_d    = sel_nxt;
          op_set_d = set_req[sel];
          busy_d   = 1'b1;
          if (set_req[sel] && clr_req[sel]) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            ack_en  = 1'b1;
            ack_idx = sel;
          end
`ifdef SRFF_SKIP_REDUNDANT_EN
          else if (set_req[sel] == q) begin
            state_d = S_DONE;
            ack_en  = 1'b1;
            ack_idx = sel;
          end
`endif
          else begin
            state_d = S_PULSE;
            s_d     = set_req[sel];
            r_d     = ~set_req[sel];
            cnt_d   = CW'(PULSE_W - 1);
          end
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          s_d     = 1'b0;
          r_d     = 1'b0;
          state_d = S_GAP;
          cnt_d   = CW'(GAP - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        // q has settled for GAP quiet cycles; check it as we enter DONE.
        if (cnt_q == '0) begin
          state_d = S_DONE;
          ack_en  = 1'b1;
          if (q != op_set_q) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    for (int i = 0; i < N; i++) ack_d[i] = ack_en && (ack_idx == PW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      op_set_q <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      op_set_q <= op_set_d;
      s_q      <= s_d;
      r_q      <= r_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
    end
  end

  assign s_out = s_q;
  assign r_out = r_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_srff_pulse_arbiter.sv
// Bench for srff_pulse_arbiter: transaction-timeline model checked every cycle, directed cases then random traffic.
// Honours SRFF_SKIP_REDUNDANT_EN in the model when the build defines it.
module tb_srff_pulse_arbiter;
  localparam int N  = 2;
  localparam int PW = 2;
  localparam int GP = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] set_req = '0;
  logic [N-1:0] clr_req = '0;
  logic [N-1:0] ack;
  logic         q, s_out, r_out, busy, err;
  logic         lq = 1'b0;
  logic         stuck0 = 1'b0;
  logic         stuck1 = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: m_t = cycle index since grant edge (-1 when idle)
  int m_t   = -1;
  int m_len = 0;
  int m_gnt = 0;
  int m_ptr = 0;
  bit m_set = 1'b0;
  bit m_norm = 1'b0;
  bit m_err = 1'b0;

  srff_pulse_arbiter #(.N(N), .PULSE_W(PW), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q(q),
    .s_out(s_out), .r_out(r_out), .ack(ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural S-R latch, with optional stuck-at overrides
  always @(posedge clk) begin
    if (s_out) lq <= 1'b1;
    else if (r_out) lq <= 1'b0;
  end
  assign q = stuck0 ? 1'b0 : (stuck1 ? 1'b1 : lq);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit found;
    int i;
    if (rst) begin
      m_t = -1; m_ptr = 0; m_err = 1'b0;
    end else if (m_t < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!found && (set_req[i] || clr_req[i])) begin
          found = 1'b1;
          m_gnt = i;
        end
      end
      if (found) begin
        m_ptr = (m_gnt + 1) % N;
        m_set = set_req[m_gnt];
        m_t   = 1;
        if (set_req[m_gnt] && clr_req[m_gnt]) begin
          m_norm = 1'b0; m_len = 1; m_err = 1'b1;
        end else begin
          m_norm = 1'b1; m_len = PW + GP + 1;
`ifdef SRFF_SKIP_REDUNDANT_EN
          if (m_set == q) begin m_norm = 1'b0; m_len = 1; end
`endif
        end
      end
    end else begin
      if (m_norm && m_t == PW + GP && q !== m_set) m_err = 1'b1;
      if (m_t == m_len) m_t = -1;
      else m_t++;
    end
  endtask

  task automatic step();
    logic [N-1:0] e_ack;
    logic e_s, e_r;
    @(posedge clk);
    model_update();
    #1;
    e_ack = (m_t > 0 && m_t == m_len) ? (N'(1) << m_gnt) : '0;
    e_s   = m_norm && m_set && m_t >= 1 && m_t <= PW;
    e_r   = m_norm && !m_set && m_t >= 1 && m_t <= PW;
    chk("s_out", 32'(s_out), 32'(e_s));
    chk("r_out", 32'(r_out), 32'(e_r));
    chk("busy",  32'(busy),  32'(m_t > 0));
    chk("ack",   32'(ack),   32'(e_ack));
    chk("err",   32'(err),   32'(m_err));
    for (int j = 0; j < N; j++) begin
      if (e_ack[j]) begin
        set_req[j] = 1'b0;
        clr_req[j] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && m_t >= 0; k++) step();
    chk("drain_idle", 32'(m_t < 0), 32'(1));
  endtask

  initial begin
    // Reset
    rst = 1'b1; step(); step();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_err",  32'(err),  32'(0));
    chk("rst_ack",  32'(ack),  32'(0));
    rst = 1'b0; step();

    // Set from requester 0
    set_req = 2'b01; step();
    chk("set_c1_s", 32'(s_out), 32'(1));
    step();
    chk("set_c2_s", 32'(s_out), 32'(1));
    step();
    chk("set_c3_s", 32'(s_out), 32'(0));
    step();
    chk("set_c4_ack", 32'(ack), 32'(2'b01));
    chk("set_c4_err", 32'(err), 32'(0));
    step();
    chk("set_q", 32'(q), 32'(1));

    // Clear from requester 1
    clr_req = 2'b10; step();
    chk("clr_c1_r", 32'(r_out), 32'(1));
    step(); step();
    chk("clr_c3_r", 32'(r_out), 32'(0));
    step();
    chk("clr_c4_ack", 32'(ack), 32'(2'b10));
    chk("clr_c4_busy", 32'(busy), 32'(1));
    step();
    chk("clr_q", 32'(q), 32'(0));
    chk("clr_c5_busy", 32'(busy), 32'(0));

    // Contention: requester 0 first, requester 1 two cycles after its ack
    set_req = 2'b01; clr_req = 2'b10;
    step(); step(); step(); step();
    chk("cont_ack0", 32'(ack), 32'(2'b01));
    step();
    chk("cont_c5_r", 32'(r_out), 32'(0));
    step();
    chk("cont_c6_r", 32'(r_out), 32'(1));
    step(); step(); step();
    chk("cont_ack1", 32'(ack), 32'(2'b10));
    drain();

    // Conflict on requester 0
    set_req = 2'b01; clr_req = 2'b01; step();
    chk("conf_ack", 32'(ack), 32'(2'b01));
    chk("conf_err", 32'(err), 32'(1));
    chk("conf_s", 32'(s_out | r_out), 32'(0));
    step();
    chk("conf_err_sticky", 32'(err), 32'(1));
    rst = 1'b1; step(); rst = 1'b0; step();
    chk("conf_err_clr", 32'(err), 32'(0));

    // Latch stuck at 0
    stuck0 = 1'b1; set_req = 2'b01;
    step(); step(); step(); step();
    chk("stuck_ack", 32'(ack), 32'(2'b01));
    chk("stuck_err", 32'(err), 32'(1));
    step();
    stuck0 = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();

    // Reset during second pulse cycle, request still held
    clr_req = 2'b01; step();
    chk("abort_c1_r", 32'(r_out), 32'(1));
    step();
    rst = 1'b1; step();
    chk("abort_r", 32'(r_out), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_ack", 32'(ack), 32'(0));
    rst = 1'b0; step();
    chk("regrant_busy", 32'(busy), 32'(1));
    drain();

`ifdef SRFF_SKIP_REDUNDANT_EN
    stuck1 = 1'b1; set_req = 2'b01; step();
    chk("skip_ack", 32'(ack), 32'(2'b01));
    chk("skip_s", 32'(s_out), 32'(0));
    chk("skip_err", 32'(err), 32'(0));
    step();
    chk("skip_busy", 32'(busy), 32'(0));
    stuck1 = 1'b0;
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (stuck0) begin
        if ($urandom_range(0, 9) == 0) stuck0 = 1'b0;
      end else if ($urandom_range(0, 149) == 0) stuck0 = 1'b1;
      for (int j = 0; j < N; j++) begin
        if (!set_req[j] && !clr_req[j] && $urandom_range(0, 3) == 0) begin
          int t;
          t = $urandom_range(0, 19);
          if (t < 9) set_req[j] = 1'b1;
          else if (t < 18) clr_req[j] = 1'b1;
          else begin set_req[j] = 1'b1; clr_req[j] = 1'b1; end
        end
      end
      step();
    end
    rst = 1'b0; stuck0 = 1'b0;
    set_req = '0; clr_req = '0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
